// File: rtl/mul_iter_if.sv
// mul_iter_if: operand/result handshake bundle for mul_iter_unit
interface mul_iter_if #(parameter int WIDTH = 512);
  logic in_valid, in_ready, in_signed, out_valid, out_ready, busy;
  logic [WIDTH-1:0] a1, a2, a3, a4;
  modport master(output in_valid, in_signed, a1, a2, out_ready, input in_ready, out_valid, a3, a4, busy);
  modport slave(input in_valid, in_signed, a1, a2, out_ready, output in_ready, out_valid, a3, a4, busy);
endinterface

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative DIGIT-bits-per-cycle signed/unsigned WIDTH x WIDTH multiplier
module mul_iter_unit #(
  parameter int WIDTH = 512,
  parameter int DIGIT = 32
) (
  input logic clk,
  input logic rst,
  mul_iter_if.slave bus
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] mcand, mplier, mag1, mag2;
  logic [2*WIDTH-1:0] acc, res;
  logic [WIDTH+DIGIT-1:0] sum;
  logic [CW-1:0] cnt;
  logic neg;
  // operand magnitudes, one partial-product step, and the sign-corrected result
  always_comb begin
    mag1 = (bus.in_signed && bus.a1[WIDTH-1]) ? -bus.a1 : bus.a1;
    mag2 = (bus.in_signed && bus.a2[WIDTH-1]) ? -bus.a2 : bus.a2;
    sum = {{DIGIT{1'b0}}, acc[2*WIDTH-1:WIDTH]} + {{DIGIT{1'b0}}, mcand} * {{WIDTH{1'b0}}, mplier[DIGIT-1:0]};
    res = neg ? -acc : acc;
  end
  // control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.in_ready <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy <= 1'b0;
      bus.a3 <= '0;
      bus.a4 <= '0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      neg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          mcand <= mag1;
          mplier <= mag2;
          neg <= bus.in_signed & (bus.a1[WIDTH-1] ^ bus.a2[WIDTH-1]);
          acc <= '0;
          cnt <= '0;
          state <= RUN;
          bus.in_ready <= 1'b0;
          bus.busy <= 1'b1;
        end
        RUN: begin
          acc <= {sum, acc[WIDTH-1:DIGIT]};
          mplier <= mplier >> DIGIT;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= FINISH;
        end
        FINISH: begin
          {bus.a4, bus.a3} <= res;
          bus.out_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready <= 1'b1;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_iter_unit.sv
// tb_mul_iter_unit: scoreboard bench for mul_iter_unit at WIDTH=8/DIGIT=4 and default size
module tb_mul_iter_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] q8[$];
  logic [1023:0] q5[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mul_iter_if #(.WIDTH(8)) f8();
  mul_iter_if f5();
  mul_iter_unit #(.WIDTH(8), .DIGIT(4)) u8 (.clk(clk), .rst(rst), .bus(f8.slave));
  mul_iter_unit u5 (.clk(clk), .rst(rst), .bus(f5.slave));

  task automatic chk(input string n, input logic [1023:0] act, input logic [1023:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // small-unit monitor: every completed handshake must match the oldest expected product
  always @(negedge clk) if (!rst && f8.out_valid && f8.out_ready) begin
    if (q8.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL u8 unexpected result: got %0h want none", {f8.a4, f8.a3});
    end else chk("u8 product", 1024'({f8.a4, f8.a3}), 1024'(q8.pop_front()));
  end

  // wide-unit monitor
  always @(negedge clk) if (!rst && f5.out_valid && f5.out_ready) begin
    if (q5.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL u5 unexpected result: got %0h want none", f5.a3);
    end else chk("u5 product", {f5.a4, f5.a3}, q5.pop_front());
  end

  task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    int c = 0;
    while (!f8.in_ready && c < 20) begin
      @(posedge clk);
      #1 c++;
    end
    chk("u8 ready", 1024'(f8.in_ready), 1024'(1));
    q8.push_back(e);
    f8.in_signed = s;
    f8.a1 = x;
    f8.a2 = y;
    f8.in_valid = 1'b1;
    @(posedge clk);
    #1 f8.in_valid = 1'b0;
    f8.a1 = ~x;
    f8.a2 = 8'h5a;
    f8.in_signed = ~s;
    chk("u8 busy", 1024'({f8.busy, f8.in_ready}), 1024'(2'b10));
    c = 0;
    while (!f8.out_valid && c < 50) begin
      @(posedge clk);
      #1 c++;
    end
    chk("u8 latency", 1024'(c), 1024'(3));
    if (f8.out_ready) begin
      @(posedge clk);
      #1 chk("u8 release", 1024'({f8.out_valid, f8.in_ready}), 1024'(2'b01));
    end
  endtask

  task automatic op5(input logic s, input logic [511:0] x, input logic [511:0] y, input logic [1023:0] e);
    int c = 0;
    q5.push_back(e);
    f5.in_signed = s;
    f5.a1 = x;
    f5.a2 = y;
    f5.in_valid = 1'b1;
    @(posedge clk);
    #1 f5.in_valid = 1'b0;
    f5.a1 = '0;
    while (!f5.out_valid && c < 100) begin
      @(posedge clk);
      #1 c++;
    end
    chk("u5 latency", 1024'(c), 1024'(17));
    @(posedge clk);
    #1 chk("u5 release", 1024'({f5.out_valid, f5.in_ready}), 1024'(2'b01));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] x, y;
    logic s;
    logic [15:0] e;
    int c, prev;
    f8.in_valid = 1'b0; f8.in_signed = 1'b0; f8.a1 = '0; f8.a2 = '0; f8.out_ready = 1'b1;
    f5.in_valid = 1'b0; f5.in_signed = 1'b0; f5.a1 = '0; f5.a2 = '0; f5.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("u8 reset", 1024'({f8.in_ready, f8.out_valid, f8.busy, f8.a4, f8.a3}), 1024'({3'b100, 16'h0}));
    chk("u5 reset", 1024'({f5.in_ready, f5.out_valid, f5.busy}), 1024'(3'b100));
    chk("u5 reset data", {f5.a4, f5.a3}, 1024'(0));
    op8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    op8(1'b1, 8'hFD, 8'h05, 16'hFFF1);
    op8(1'b0, 8'hFD, 8'h05, 16'h04F1);
    op8(1'b1, 8'hFF, 8'hFF, 16'h0001);
    op8(1'b1, 8'h80, 8'h80, 16'h4000);
    op8(1'b1, 8'h7F, 8'h80, 16'hC080);
    op8(1'b1, 8'h00, 8'hF9, 16'h0000);
    op5(1'b0, '1, '1, {{511{1'b1}}, 1'b0, {511{1'b0}}, 1'b1});
    op5(1'b1, '1, 512'd2, {{1023{1'b1}}, 1'b0});
    f8.out_ready = 1'b0;
    op8(1'b0, 8'h12, 8'h34, 16'h03A8);
    for (int i = 0; i < 20; i++) begin
      f8.in_valid = i[0];
      f8.a1 = 8'h11;
      f8.a2 = 8'h22;
      @(posedge clk);
      #1 chk("u8 hold", 1024'({f8.out_valid, f8.in_ready, f8.a4, f8.a3}), 1024'({2'b10, 16'h03A8}));
    end
    f8.in_valid = 1'b0;
    f8.out_ready = 1'b1;
    @(posedge clk);
    #1 chk("u8 bp release", 1024'({f8.out_valid, f8.in_ready, f8.a4, f8.a3}), 1024'({2'b01, 16'h03A8}));
    f8.in_signed = 1'b0; f8.a1 = 8'h09; f8.a2 = 8'h09; f8.in_valid = 1'b1;
    @(posedge clk);
    #1 f8.in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("u8 abort", 1024'({f8.out_valid, f8.in_ready, f8.busy, f8.a4, f8.a3}), 1024'({3'b010, 16'h0}));
    repeat (4) @(posedge clk);
    #1 chk("u8 abort quiet", 1024'({f8.out_valid, f8.in_ready}), 1024'(2'b01));
    op8(1'b0, 8'h06, 8'h07, 16'h002A);
    f8.in_valid = 1'b1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      e = s ? $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y}) : {8'h0, x} * {8'h0, y};
      c = 0;
      while (!f8.in_ready && c < 20) begin
        @(posedge clk);
        #1 c++;
      end
      chk("u8 b2b ready", 1024'(f8.in_ready), 1024'(1));
      q8.push_back(e);
      f8.in_signed = s;
      f8.a1 = x;
      f8.a2 = y;
      @(posedge clk);
      #1 if (k > 0) chk("u8 spacing", 1024'(cyc - prev), 1024'(5));
      prev = cyc;
    end
    f8.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("u8 drained", 1024'(q8.size()), 1024'(0));
    chk("u5 drained", 1024'(q5.size()), 1024'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mul_iter_unit.md
Name: mul_iter_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle wide multiplier in the math datapath.
- Computes the full 2*WIDTH-bit product of two WIDTH-bit operands, signed or unsigned per operation.
- Processes DIGIT multiplier bits per cycle, so area and timing scale with DIGIT rather than WIDTH.
- Uses valid/ready handshakes on input and output and returns the product as low half (a3) and high half (a4).

Parameters:
WIDTH, 512, operand width in bits; must be a multiple of DIGIT.
DIGIT, 32, multiplier bits retired per cycle; N = WIDTH/DIGIT iterations.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand pair present.
in_ready  out  1  block can accept operands.
in_signed  in  1  1: two's-complement operands and result; 0: unsigned.
a1  in  WIDTH  multiplicand.
a2  in  WIDTH  multiplier.
out_valid  out  1  result present on a3/a4.
out_ready  in  1  consumer accepts result.
a3  out  WIDTH  product[WIDTH-1:0].
a4  out  WIDTH  product[2*WIDTH-1:WIDTH].
busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst and overrides all other inputs.
- Reset state: state=IDLE, in_ready=1, out_valid=0, busy=0, a3=0, a4=0, iteration counter=0, accumulator=0.
- States: IDLE, RUN, FINISH, DONE.
- IDLE:
  - in_ready=1.
  - An accept occurs on an edge with in_valid=1.
  - On accept: latch |a1| and |a2| (magnitudes when in_signed=1, raw values otherwise), latch neg = in_signed & (a1[MSB] ^ a2[MSB]), clear accumulator and counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: acc_hi += mcand * mplier[DIGIT-1:0]; the 2*WIDTH accumulator shifts right by DIGIT; the multiplier shifts right by DIGIT; counter increments.
  - After exactly N RUN cycles, go to FINISH.
- FINISH (one cycle):
  - Write a3/a4 from the accumulator, two's-complement negated over 2*WIDTH bits if neg=1.
  - Set out_valid=1 and go to DONE.
- DONE:
  - out_valid=1.
  - a3/a4 and out_valid hold stable while out_ready=0 (backpressure of any length).
  - On an edge with out_ready=1: out_valid drops and the state returns to IDLE. in_ready is high from the next cycle.
- Latency: out_valid is first high N+1 cycles after the accept edge.
  - Minimum initiation interval is N+3 cycles when out_ready is held at 1.
  - No overlap of operations; in_valid is ignored outside IDLE.
- Input stability: a1, a2 and in_signed are sampled only on the accept edge and may change afterwards.
- Output retention: a3/a4 keep the last result after the DONE->IDLE transition until the next FINISH overwrites them.
- Arithmetic: the result is exact over 2*WIDTH bits with no truncation or saturation.
  - Signed most-negative operand: magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits. (-2^(W-1))^2 = 2^(2W-2) is representable.
  - Zero operand: the result is 0 with neg ignored (negating 0 gives 0).
- Reset mid-operation: rst in RUN, FINISH or DONE aborts the operation. All registers return to their reset values and no out_valid pulse appears.
- Simultaneous events: in DONE with out_ready=1 and in_valid=1, the operand is not accepted that edge. It is accepted on the next edge in IDLE if in_valid is still high.

Test Plan:
1. WIDTH=8, DIGIT=4, unsigned, a1=0xFF, a2=0xFF, out_ready=1 -> out_valid high 3 cycles after accept; a4=0xFE, a3=0x01.
2. WIDTH=8, DIGIT=4, signed: (-3)*(5) -> a4=0xFF, a3=0xF1; (-1)*(-1) -> a4=0x00, a3=0x01; (-128)*(-128) -> a4=0x40, a3=0x00; 0*(-7) -> a4=0x00, a3=0x00.
3. Defaults (WIDTH=512, DIGIT=32), unsigned, a1=a2=2^512-1 -> out_valid 17 cycles after accept; a4=2^512-2, a3=1.
4. Backpressure: hold out_ready=0 for 20 cycles in DONE -> a3/a4/out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> one-cycle handshake, in_ready=1 the following cycle.
5. Reset mid-RUN: assert rst on the 2nd RUN cycle -> next cycle out_valid=0, a3=a4=0, in_ready=1. A new op 6*7 (WIDTH=8) then yields a3=0x2A, a4=0x00.
6. Back-to-back: keep in_valid=1 with out_ready=1 tied high and apply 5 random signed/unsigned operand pairs -> each accepted exactly once, spacing N+3 cycles, results match a reference 2*WIDTH product.
